// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID/EX/MEM operand and destination bundle plus stall/bubble outputs
interface hazard_stall_ctrl_if #(parameter int REG_W = 6);
  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_branch;
  logic             id_multi;
  logic             ex_regwrite;
  logic             ex_mem2reg;
  logic [REG_W-1:0] ex_rd;
  logic             mem_regwrite;
  logic             mem_mem2reg;
  logic [REG_W-1:0] mem_rd;
  logic             stall_if;
  logic             bubble_ex;
  logic             multi_busy;
  logic [31:0]      stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_multi,
    output ex_regwrite, ex_mem2reg, ex_rd, mem_regwrite, mem_mem2reg, mem_rd,
    input  stall_if, bubble_ex, multi_busy, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_branch, id_multi,
    input  ex_regwrite, ex_mem2reg, ex_rd, mem_regwrite, mem_mem2reg, mem_rd,
    output stall_if, bubble_ex, multi_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage interlock (load-use, branch operand, multi-cycle occupancy); HAZ_PERF_CNT_EN adds a saturating stall counter
module hazard_stall_ctrl #(
  parameter int REG_W     = 6,
  parameter int MULTI_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_ctrl_if.slave io
);
  if (MULTI_LAT < 1 || MULTI_LAT > 16) begin : g_bad_lat
    $error("hazard_stall_ctrl: MULTI_LAT must be 1..16");
  end
  typedef enum logic {RUN, MULTI} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic       w_hit_ex, w_hit_mem, w_haz, w_stall, w_busy;
  // A nonzero id matches a used source; id 0 is integer r0, FP f0 has the top bit set
  assign w_hit_ex  = io.id_valid && io.ex_rd != '0 &&
                     ((io.id_use_rs1 && io.id_rs1 == io.ex_rd) || (io.id_use_rs2 && io.id_rs2 == io.ex_rd));
  assign w_hit_mem = io.id_valid && io.mem_rd != '0 &&
                     ((io.id_use_rs1 && io.id_rs1 == io.mem_rd) || (io.id_use_rs2 && io.id_rs2 == io.mem_rd));
  assign w_haz = w_hit_ex && io.ex_regwrite && (io.ex_mem2reg || io.id_branch) ||
                 w_hit_mem && io.id_branch && io.mem_mem2reg && io.mem_regwrite;
  // State and occupancy counter; reset abandons any multi-cycle op at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  // Next state: hazards block multi issue; MULTI counts down MULTI_LAT-1 stall cycles
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = w_haz;
    w_busy     = 1'b0;
    if (r_state == MULTI) begin
      w_stall    = 1'b1;
      w_busy     = 1'b1;
      w_cnt_next = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_next     = RUN;
        w_cnt_next = '0;
      end
    end else if (io.id_valid && io.id_multi && !w_haz && MULTI_LAT > 1) begin
      w_next     = MULTI;
      w_cnt_next = 4'(MULTI_LAT - 1);
    end
  end
  assign io.stall_if   = rst_n && w_stall;
  assign io.bubble_ex  = rst_n && w_stall;
  assign io.multi_busy = rst_n && w_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  // Stall-cycle counter saturates rather than wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  assign io.stall_cycles = r_stall_cnt;
`else
  assign io.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors with a scoreboard queue checked by an independent monitor
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hazard_stall_ctrl_if #(.REG_W(6)) bus ();
  hazard_stall_ctrl #(.REG_W(6), .MULTI_LAT(4)) dut (.clk(clk), .rst_n(rst_n), .io(bus));
  typedef struct {
    string       nm;
    logic [2:0]  o;
    logic [31:0] sc;
  } exp_t;
  exp_t        q[$];
  exp_t        m_e;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_sc = 0;
  // Monitor: compares outputs mid-cycle whenever an expectation is pending
  always @(negedge clk)
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_chk += 2;
      if ({bus.stall_if, bus.bubble_ex, bus.multi_busy} === m_e.o) n_pass++;
      else $display("FAIL %s: {stall_if,bubble_ex,multi_busy} actual=%b required=%b", m_e.nm,
                    {bus.stall_if, bus.bubble_ex, bus.multi_busy}, m_e.o);
      if (bus.stall_cycles === m_e.sc) n_pass++;
      else $display("FAIL %s: stall_cycles actual=%h required=%h", m_e.nm, bus.stall_cycles, m_e.sc);
    end
  task automatic vec(input string nm, input int rn, input int v, input int r1, input int r2,
                     input int u1, input int u2, input int br, input int mu, input int ew,
                     input int el, input int ed, input int mw, input int ml, input int md,
                     input logic [2:0] e);
    logic [31:0] sc;
    @(posedge clk);
    #1;
    rst_n            = 1'(rn);
    bus.id_valid     = 1'(v);
    bus.id_rs1       = 6'(r1);
    bus.id_rs2       = 6'(r2);
    bus.id_use_rs1   = 1'(u1);
    bus.id_use_rs2   = 1'(u2);
    bus.id_branch    = 1'(br);
    bus.id_multi     = 1'(mu);
    bus.ex_regwrite  = 1'(ew);
    bus.ex_mem2reg   = 1'(el);
    bus.ex_rd        = 6'(ed);
    bus.mem_regwrite = 1'(mw);
    bus.mem_mem2reg  = 1'(ml);
    bus.mem_rd       = 6'(md);
    if (rn == 0) m_sc = 0;
`ifdef HAZ_PERF_CNT_EN
    sc = m_sc;
`else
    sc = 32'd0;
`endif
    q.push_back('{nm, e, sc});
    if (e[2] && rn != 0 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
  endtask
  initial begin
    //  name            rn v  rs1    rs2 u1 u2 br mu ew el exrd   mw ml mrd   exp
    vec("rst_hold",     0, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b000);
    vec("idle",         1, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("load_use",     1, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("lu_release",   1, 1, 5,     0,  1, 0, 0, 0, 0, 0, 0,     1, 1, 5,  3'b000);
    vec("r0_exempt",    1, 1, 0,     0,  1, 0, 0, 0, 1, 1, 0,     0, 0, 0,  3'b000);
    vec("fp_f0",        1, 1, 'h20,  0,  1, 0, 0, 0, 1, 1, 'h20,  0, 0, 0,  3'b110);
    vec("int_vs_fp",    1, 1, 'h05,  0,  1, 0, 0, 0, 1, 1, 'h25,  0, 0, 0,  3'b000);
    vec("no_use",       1, 1, 5,     0,  0, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b000);
    vec("id_bubble",    1, 0, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b000);
    vec("ld_nowr",      1, 1, 5,     0,  1, 0, 0, 0, 0, 1, 5,     0, 0, 0,  3'b000);
    vec("rs2_lu",       1, 1, 0,     9,  0, 1, 0, 0, 1, 1, 9,     0, 0, 0,  3'b110);
    vec("br_alu",       1, 1, 0,     8,  0, 1, 1, 0, 1, 0, 8,     0, 0, 0,  3'b110);
    vec("br_alu_rel",   1, 1, 0,     8,  0, 1, 1, 0, 0, 0, 0,     1, 0, 8,  3'b000);
    vec("br_ld_ex",     1, 1, 0,     8,  0, 1, 1, 0, 1, 1, 8,     0, 0, 0,  3'b110);
    vec("br_ld_mem",    1, 1, 0,     8,  0, 1, 1, 0, 0, 0, 0,     1, 1, 8,  3'b110);
    vec("br_ld_rel",    1, 1, 0,     8,  0, 1, 1, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("multi_t",      1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("multi_t1",     1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("multi_t2_haz", 1, 1, 5,     0,  1, 0, 0, 1, 1, 1, 5,     0, 0, 0,  3'b111);
    vec("multi_t3",     1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("b2b_issue",    1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("b2b_1",        1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("b2b_2",        1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("b2b_3",        1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("b2b_done",     1, 1, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("multi_haz",    1, 1, 5,     0,  1, 0, 0, 1, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("multi_late",   1, 1, 5,     0,  1, 0, 0, 1, 0, 0, 0,     1, 1, 5,  3'b000);
    vec("late_1",       1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("late_2",       1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("late_3",       1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("late_done",    1, 1, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("rst_issue",    1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("rst_t1",       1, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b111);
    vec("rst_mid",      0, 1, 0,     0,  0, 0, 0, 1, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("post_rst",     1, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("post_rst_2",   1, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
    vec("post_lu",      1, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("post_idle",    1, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
`ifdef HAZ_PERF_CNT_EN
    @(posedge clk);
    #1;
    dut.r_stall_cnt = 32'hFFFF_FFFE;
    m_sc = 32'hFFFF_FFFE;
    vec("sat_1",        1, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("sat_2",        1, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("sat_3",        1, 1, 5,     0,  1, 0, 0, 0, 1, 1, 5,     0, 0, 0,  3'b110);
    vec("sat_hold",     1, 0, 0,     0,  0, 0, 0, 0, 0, 0, 0,     0, 0, 0,  3'b000);
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: pending expectations actual=%0d required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
